// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   INS_W       : instruction word width (64 bits)
//   ifu_state_e : fetch controller state encoding (IDLE/FETCH/HALT)
package ifu_pkg;

    localparam int INS_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_buf.sv
// ifu_buf: 2-entry instruction FIFO sitting between the SRAM read port and
// the decode handshake. Absorbs the one-cycle SRAM latency so a stalled
// decode stage never causes an instruction to be lost or repeated.
// Ports:
//   clk, rst_n   : clock, asynchronous active-high reset
//   flush        : empty the FIFO (takes priority over enq/deq)
//   enq/enq_data : write one word at the tail
//   deq          : pop the head word
//   count        : current occupancy (0..2)
//   head         : word at the head of the FIFO
module ifu_buf
    import ifu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             enq,
    input  logic [INS_W-1:0] enq_data,
    input  logic             deq,
    output logic [1:0]       count,
    output logic [INS_W-1:0] head
);

    logic [INS_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage is cleared on reset so the head output reads as zero out of reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= enq_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // The issue rule upstream guarantees a free slot for every returning read.
    assert property (@(posedge clk) disable iff (rst_n)
                     !(enq && !deq && !flush && count == 2'd2));

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit. Reads 64-bit words from a synchronous SRAM at
// an incrementing PC and hands them to decode over a valid/ready handshake.
// Ports:
//   clk, rst_n              : clock, asynchronous active-high reset
//   start, start_pc         : (re)start fetching at start_pc
//   imem_ren, imem_addr     : SRAM read request (data returns next cycle)
//   imem_rdata              : SRAM read data
//   ifu_idu_vld/ifu_idu_ins : instruction to decode
//   idu_ifu_rdy             : decode accepts the presented instruction
//   idu_ifu_wfi             : decode holds a WFI, stop fetching
//   ifu_busy, ifu_done      : state is FETCH / state is HALT
module ifu
    import ifu_pkg::*;
#(
    parameter int IMEM_AW = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IMEM_AW-1:0] start_pc,
    output logic               imem_ren,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INS_W-1:0]   imem_rdata,
    output logic               ifu_idu_vld,
    output logic [INS_W-1:0]   ifu_idu_ins,
    input  logic               idu_ifu_rdy,
    input  logic               idu_ifu_wfi,
    output logic               ifu_busy,
    output logic               ifu_done
);

    ifu_state_e         state;
    logic [IMEM_AW-1:0] pc;
    logic               inflight;

    logic               in_fetch;
    logic               discard;
    logic               deq;
    logic               enq;
    logic               issue;
    logic               flush;
    logic [1:0]         count;
    logic [2:0]         occupancy;

    assign in_fetch = (state == ST_FETCH);

    // A start or WFI this cycle throws away whatever read is returning now.
    assign discard = start | idu_ifu_wfi;

    assign ifu_idu_vld = (count != 2'd0) & in_fetch & ~idu_ifu_wfi;
    assign deq         = ifu_idu_vld & idu_ifu_rdy;

    // Words that will occupy the buffer once the pending read lands; deq
    // only happens with count >= 1, so this never underflows.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
    assign issue     = in_fetch & ~discard & (occupancy < 3'd2);
    assign enq       = in_fetch & inflight & ~discard;
    assign flush     = start | (in_fetch & idu_ifu_wfi);

    assign imem_ren  = issue;
    assign imem_addr = pc;
    assign ifu_busy  = in_fetch;
    assign ifu_done  = (state == ST_HALT);

    // Fetch controller: start always wins, WFI parks the unit in HALT, and
    // the in-flight flag tracks whether the next rdata belongs to us.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (start) begin
                state <= ST_FETCH;
                pc    <= start_pc;
            end else begin
                if (in_fetch && idu_ifu_wfi) begin
                    state <= ST_HALT;
                end
                if (issue) begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

    ifu_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .enq      (enq),
        .enq_data (imem_rdata),
        .deq      (deq),
        .count    (count),
        .head     (ifu_idu_ins)
    );

endmodule
